// File: rtl/shift_exec_pipe.sv
// Two-stage valid/ready execute pipe for SLL/SRL/SRA.
// Stage D holds the decoded operation; stage E holds the registered result.
module shift_exec_pipe #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       IN_FUNCT3,
    input  logic             IN_FUNCT7_5,
    input  logic [31:0]      IN_RS1,
    input  logic [31:0]      IN_RS2,
    input  logic [4:0]       IN_IMM,
    input  logic             IN_USE_IMM,
    input  logic [TAG_W-1:0] IN_TAG,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_RESULT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_ILLEGAL
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned MODE_W  = 2;

    localparam logic [MODE_W-1:0] MODE_SLL = 2'b00;
    localparam logic [MODE_W-1:0] MODE_SRL = 2'b01;
    localparam logic [MODE_W-1:0] MODE_SRA = 2'b10;

    logic               d_valid;
    logic [MODE_W-1:0]  d_mode;
    logic [DATA_W-1:0]  d_operand;
    logic [SHAMT_W-1:0] d_shamt;
    logic [TAG_W-1:0]   d_tag;
    logic               d_illegal;

    logic               e_adv;
    logic               d_adv;
    logic               accept;
    logic [MODE_W-1:0]  in_mode;
    logic               in_illegal;
    logic [SHAMT_W-1:0] in_shamt;
    logic [DATA_W-1:0]  e_result;
    logic               unused_rs2_hi;

    assign e_adv    = !OUT_VALID || OUT_READY;
    assign d_adv    = !d_valid || e_adv;
    assign IN_READY = d_adv && !FLUSH;
    assign accept   = IN_VALID && IN_READY;

    assign in_shamt      = IN_USE_IMM ? IN_IMM : IN_RS2[SHAMT_W-1:0];
    assign unused_rs2_hi = ^IN_RS2[DATA_W-1:SHAMT_W];

    // Decode funct3/funct7[5] into a shift mode; unknown encodings are illegal
    always_comb begin
        in_mode    = MODE_SLL;
        in_illegal = 1'b1;
        case (IN_FUNCT3)
            3'b001: begin
                if (!IN_FUNCT7_5) begin
                    in_illegal = 1'b0;
                end
            end
            3'b101: begin
                in_illegal = 1'b0;
                in_mode    = IN_FUNCT7_5 ? MODE_SRA : MODE_SRL;
            end
            default: ;
        endcase
    end

    // Single-cycle shifter between D and E
    always_comb begin
        e_result = '0;
        if (!d_illegal) begin
            case (d_mode)
                MODE_SLL: e_result = d_operand << d_shamt;
                MODE_SRL: e_result = d_operand >> d_shamt;
                MODE_SRA: e_result = DATA_W'($signed(d_operand) >>> d_shamt);
                default:  e_result = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_valid   <= 1'b0;
            d_mode    <= '0;
            d_operand <= '0;
            d_shamt   <= '0;
            d_tag     <= '0;
            d_illegal <= 1'b0;
        end else begin
            if (FLUSH) begin
                d_valid <= 1'b0;
            end else if (d_adv) begin
                d_valid <= accept;
            end
            if (accept) begin
                d_mode    <= in_mode;
                d_operand <= IN_RS1;
                d_shamt   <= in_shamt;
                d_tag     <= IN_TAG;
                d_illegal <= in_illegal;
            end
        end
    end

    // Output stage: data only reloads when a valid op moves out of D
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID   <= 1'b0;
            OUT_RESULT  <= '0;
            OUT_TAG     <= '0;
            OUT_ILLEGAL <= 1'b0;
        end else begin
            if (FLUSH) begin
                OUT_VALID <= 1'b0;
            end else if (e_adv) begin
                OUT_VALID <= d_valid;
            end
            if (e_adv && d_valid) begin
                OUT_RESULT  <= e_result;
                OUT_TAG     <= d_tag;
                OUT_ILLEGAL <= d_illegal;
            end
        end
    end

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed bench for shift_exec_pipe: streamed vector table plus
// backpressure, flush and mid-stream reset sequences.
module tb_shift_exec_pipe;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned NVEC  = 12;

    typedef struct {
        logic [2:0]       funct3;
        logic             f7_5;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [4:0]       imm;
        logic             use_imm;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp_result;
        logic             exp_illegal;
    } vec_t;

    logic             CLK;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [2:0]       IN_FUNCT3;
    logic             IN_FUNCT7_5;
    logic [31:0]      IN_RS1;
    logic [31:0]      IN_RS2;
    logic [4:0]       IN_IMM;
    logic             IN_USE_IMM;
    logic [TAG_W-1:0] IN_TAG;
    logic             FLUSH;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [31:0]      OUT_RESULT;
    logic [TAG_W-1:0] OUT_TAG;
    logic             OUT_ILLEGAL;

    int checks = 0;
    int errors = 0;
    vec_t vec [NVEC];

    shift_exec_pipe #(.TAG_W(TAG_W)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_FUNCT3(IN_FUNCT3), .IN_FUNCT7_5(IN_FUNCT7_5),
        .IN_RS1(IN_RS1), .IN_RS2(IN_RS2), .IN_IMM(IN_IMM),
        .IN_USE_IMM(IN_USE_IMM), .IN_TAG(IN_TAG), .FLUSH(FLUSH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_RESULT(OUT_RESULT), .OUT_TAG(OUT_TAG), .OUT_ILLEGAL(OUT_ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic f7, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [4:0] imm, input logic ui,
                                input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic ill);
        vec_t v;
        v.funct3 = f3; v.f7_5 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.use_imm = ui; v.tag = tag; v.exp_result = res; v.exp_illegal = ill;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        IN_VALID    = 1'b1;
        IN_FUNCT3   = v.funct3;
        IN_FUNCT7_5 = v.f7_5;
        IN_RS1      = v.rs1;
        IN_RS2      = v.rs2;
        IN_IMM      = v.imm;
        IN_USE_IMM  = v.use_imm;
        IN_TAG      = v.tag;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string name, input vec_t v);
        chk({name, ".valid"}, 32'(OUT_VALID), 32'd1);
        chk({name, ".result"}, OUT_RESULT, v.exp_result);
        chk({name, ".tag"}, 32'(OUT_TAG), 32'(v.tag));
        chk({name, ".illegal"}, 32'(OUT_ILLEGAL), 32'(v.exp_illegal));
    endtask

    initial begin
        vec_t a, b, c;

        vec[0]  = mk(3'b001, 1'b0, 32'h0000_0001, 32'h0,          5'd31, 1'b1, 5'd3,  32'h8000_0000, 1'b0);
        vec[1]  = mk(3'b101, 1'b1, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0,  1'b0, 5'd4,  32'hF800_0000, 1'b0);
        vec[2]  = mk(3'b101, 1'b0, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0,  1'b0, 5'd5,  32'h0800_0000, 1'b0);
        vec[3]  = mk(3'b010, 1'b0, 32'h0000_1234, 32'h1,          5'd1,  1'b1, 5'd6,  32'h0,         1'b1);
        vec[4]  = mk(3'b001, 1'b1, 32'h0000_1234, 32'h1,          5'd1,  1'b1, 5'd7,  32'h0,         1'b1);
        vec[5]  = mk(3'b001, 1'b0, 32'hDEAD_BEEF, 32'h0,          5'd9,  1'b0, 5'd8,  32'hDEAD_BEEF, 1'b0);
        vec[6]  = mk(3'b101, 1'b1, 32'h7FFF_FFFF, 32'h0,          5'd31, 1'b1, 5'd9,  32'h0,         1'b0);
        vec[7]  = mk(3'b101, 1'b1, 32'hFFFF_0000, 32'h0000_0010, 5'd0,  1'b0, 5'd10, 32'hFFFF_FFFF, 1'b0);
        vec[8]  = mk(3'b101, 1'b0, 32'hFFFF_0000, 32'h0,          5'd16, 1'b1, 5'd11, 32'h0000_FFFF, 1'b0);
        vec[9]  = mk(3'b001, 1'b0, 32'h0000_ABCD, 32'h0000_0028, 5'd0,  1'b0, 5'd12, 32'h00AB_CD00, 1'b0);
        vec[10] = mk(3'b001, 1'b0, 32'h0000_0003, 32'h0000_0005, 5'd1,  1'b1, 5'd13, 32'h0000_0006, 1'b0);
        vec[11] = mk(3'b101, 1'b1, 32'h8000_0001, 32'h0000_0003, 5'd0,  1'b1, 5'd31, 32'h8000_0001, 1'b0);

        RST = 1'b1; IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b1;
        drive(vec[0]); IN_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset.out_valid", 32'(OUT_VALID), 32'd0);
        chk("reset.out_result", OUT_RESULT, 32'd0);
        RST = 1'b0;
        #1;
        chk("reset.in_ready", 32'(IN_READY), 32'd1);
        step();

        // Stream the table back-to-back at full throughput
        for (int i = 0; i <= int'(NVEC); i++) begin
            if (i < int'(NVEC)) begin
                drive(vec[i]);
                #0 chk($sformatf("stream%0d.in_ready", i), 32'(IN_READY), 32'd1);
            end else begin
                IN_VALID = 1'b0;
            end
            step();
            if (i >= 1) chk_out($sformatf("vec%0d", i - 1), vec[i - 1]);
        end
        step();
        chk("drain.out_valid", 32'(OUT_VALID), 32'd0);

        // Backpressure: two accepted, third held, then all three in order
        a = mk(3'b001, 1'b0, 32'h0000_0001, 32'h0, 5'd4,  1'b1, 5'd20, 32'h0000_0010, 1'b0);
        b = mk(3'b101, 1'b0, 32'h0000_0100, 32'h0, 5'd8,  1'b1, 5'd21, 32'h0000_0001, 1'b0);
        c = mk(3'b101, 1'b1, 32'h8000_0000, 32'h0, 5'd31, 1'b1, 5'd22, 32'hFFFF_FFFF, 1'b0);
        OUT_READY = 1'b0;
        drive(a); #0 chk("bp.ready_a", 32'(IN_READY), 32'd1); step();
        drive(b); #0 chk("bp.ready_b", 32'(IN_READY), 32'd1); step();
        drive(c); #0 chk("bp.ready_c_blocked", 32'(IN_READY), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp.hold%0d.in_ready", k), 32'(IN_READY), 32'd0);
            chk_out($sformatf("bp.hold%0d", k), a);
        end
        OUT_READY = 1'b1;
        #1 chk("bp.ready_rise", 32'(IN_READY), 32'd1);
        step(); IN_VALID = 1'b0;
        chk_out("bp.out_b", b);
        step();
        chk_out("bp.out_c", c);
        step();
        chk("bp.empty", 32'(OUT_VALID), 32'd0);

        // Flush with two in flight; the input offered during flush is dropped
        OUT_READY = 1'b0;
        drive(a); step();
        drive(b); step();
        drive(c); FLUSH = 1'b1;
        #0 chk("flush.in_ready", 32'(IN_READY), 32'd0);
        step();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        chk("flush.out_valid", 32'(OUT_VALID), 32'd0);
        OUT_READY = 1'b1;
        step();
        chk("flush.empty1", 32'(OUT_VALID), 32'd0);
        step();
        chk("flush.empty2", 32'(OUT_VALID), 32'd0);

        // Asynchronous reset while full, then 2-cycle latency after release
        OUT_READY = 1'b0;
        drive(vec[1]); step();
        drive(vec[0]); step();
        IN_VALID = 1'b0;
        chk_out("prereset", vec[1]);
        #2 RST = 1'b1;
        #1;
        chk("rst.out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst.out_result", OUT_RESULT, 32'd0);
        chk("rst.out_tag", 32'(OUT_TAG), 32'd0);
        chk("rst.out_illegal", 32'(OUT_ILLEGAL), 32'd0);
        @(negedge CLK);
        RST = 1'b0; OUT_READY = 1'b1;
        step();
        chk("postrst.empty", 32'(OUT_VALID), 32'd0);
        drive(vec[9]); step();
        IN_VALID = 1'b0;
        chk("postrst.lat1", 32'(OUT_VALID), 32'd0);
        step();
        chk_out("postrst.lat2", vec[9]);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
